// File: rtl/uart_mmio_unit.sv
// Memory-mapped UART behind the LSU: DATA/STATUS registers, 8N1 TX and RX
// engines, and a registered get pulse that completes UART loads.
module uart_mmio_unit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] rdata,
    output logic        get,
    output logic        tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state;
    logic [CW-1:0]    tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;

    rx_state_t        rx_state;
    logic [CW-1:0]    rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic             rx_s;
    logic             rx_prev;

    logic             rx_valid;
    logic [7:0]       rx_buf;
    logic             rx_overrun;
    logic             rx_frame_err;
    logic             tx_drop;

    logic [1:0]       reg_sel;
    logic             is_write;
    logic             is_read;
    logic             data_store;
    logic             load_fire;
    logic             data_take;
    logic             status_take;
    logic             rx_stop_sample;
    logic             rx_done_ok;
    logic             rx_done_err;
    logic [31:0]      status;
    logic [31:0]      load_value;
    logic             unused_bits;

    assign unused_bits = ^{address[31:4], address[1:0], wdata[31:8]};
    assign reg_sel     = address[3:2];
    assign rx_s        = rx_sync[SYNC_STAGES-1];

    // A load is only considered while get is low, so a held read after a
    // pulse starts a fresh access one cycle later.
    always_comb begin
        is_write       = uart & write;
        is_read        = uart & read & ~write;
        data_store     = is_write && (reg_sel == 2'd0);
        load_fire      = is_read && !get && ((reg_sel != 2'd0) || rx_valid);
        data_take      = load_fire && (reg_sel == 2'd0);
        status_take    = load_fire && (reg_sel == 2'd1);
        rx_stop_sample = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
        rx_done_ok     = rx_stop_sample & rx_s;
        rx_done_err    = rx_stop_sample & ~rx_s;
        status         = {27'b0, tx_drop, rx_frame_err, rx_overrun, tx_busy, rx_valid};
        case (reg_sel)
            2'd0:    load_value = {24'b0, rx_buf};
            2'd1:    load_value = status;
            default: load_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (data_store) begin
                        tx_shift <= wdata[7:0];
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx       <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= '1;
        end else begin
            rx_sync[0] <= rx;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                rx_sync[i] <= rx_sync[i-1];
            end
        end
    end

    // START waits half a bit so every later sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_prev  <= 1'b1;
        end else begin
            rx_prev <= rx_s;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a STATUS read wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            get          <= 1'b0;
            rdata        <= '0;
            rx_valid     <= 1'b0;
            rx_buf       <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_drop      <= 1'b0;
        end else begin
            get   <= load_fire;
            rdata <= load_fire ? load_value : '0;
            if (rx_done_ok && (!rx_valid || data_take)) begin
                rx_buf   <= rx_shift;
                rx_valid <= 1'b1;
            end else if (data_take) begin
                rx_valid <= 1'b0;
            end
            rx_overrun   <= (rx_done_ok && rx_valid && !data_take) || (rx_overrun && !status_take);
            rx_frame_err <= rx_done_err || (rx_frame_err && !status_take);
            tx_drop      <= (data_store && tx_busy) || (tx_drop && !status_take);
        end
    end

endmodule

// File: tb/tb_uart_mmio_unit.sv
// Directed bench for uart_mmio_unit at CLKS_PER_BIT=4: TX framing, loads,
// RX receive/overrun/framing error, glitch rejection and mid-frame reset.
module tb_uart_mmio_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart;
    logic        write;
    logic        read;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        rx;
    logic        tx;
    logic [31:0] rdata;
    logic        get;
    logic        tx_busy;

    int tests  = 0;
    int failed = 0;

    uart_mmio_unit #(.CLKS_PER_BIT(4), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart    (uart),
        .write   (write),
        .read    (read),
        .address (address),
        .wdata   (wdata),
        .rx      (rx),
        .tx      (tx),
        .rdata   (rdata),
        .get     (get),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        uart = 1'b1; read = 1'b1; address = addr;
        @(negedge clk);
        chk({tag, "_get"}, {31'b0, get}, 32'd1);
        chk(tag, rdata, exp);
        read = 1'b0; uart = 1'b0;
        @(negedge clk);
        chk({tag, "_end"}, {31'b0, get}, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            rx = f[k/4];
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;

        rst = 1'b1; uart = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; wdata = '0; rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_get", {31'b0, get}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", {31'b0, tx_busy}, 32'd0);
        rst = 1'b0;

        // TX frame 0xA5, with a dropped store and a STATUS read inside it
        @(negedge clk);
        uart = 1'b1; write = 1'b1; address = 32'h0; wdata = 32'h0000_00A5;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("tx_bit", {31'b0, tx}, {31'b0, frame[k/4]});
            chk("tx_busy", {31'b0, tx_busy}, 32'd1);
            if (k == 0) write = 1'b0;
            if (k == 10) begin write = 1'b1; wdata = 32'h0000_003C; end
            if (k == 11) write = 1'b0;
            if (k == 20) begin
                chk("stat_pre_get", {31'b0, get}, 32'd0);
                read = 1'b1; address = 32'h4;
            end
            if (k == 21) begin
                chk("stat_busy_get", {31'b0, get}, 32'd1);
                chk("stat_busy", rdata, 32'h12);
                read = 1'b0;
            end
            if (k == 22) chk("stat_busy_end", {31'b0, get}, 32'd0);
        end
        @(negedge clk);
        chk("tx_idle_busy", {31'b0, tx_busy}, 32'd0);
        chk("tx_idle_line", {31'b0, tx}, 32'd1);

        // Back-to-back STATUS loads with read held: pulse, gap, pulse
        read = 1'b1; address = 32'h4;
        @(negedge clk);
        chk("b2b_get1", {31'b0, get}, 32'd1);
        chk("b2b_stat1", rdata, 32'h0);
        @(negedge clk);
        chk("b2b_gap", {31'b0, get}, 32'd0);
        @(negedge clk);
        chk("b2b_get2", {31'b0, get}, 32'd1);
        chk("b2b_stat2", rdata, 32'h0);
        read = 1'b0; uart = 1'b0;

        // Write and read together is a write only: no get
        @(negedge clk);
        uart = 1'b1; write = 1'b1; read = 1'b1; address = 32'h4;
        @(negedge clk);
        chk("wr_rd_get0", {31'b0, get}, 32'd0);
        @(negedge clk);
        chk("wr_rd_get1", {31'b0, get}, 32'd0);
        write = 1'b0; read = 1'b0; uart = 1'b0;
        do_load("reg2", 32'h8, 32'h0);

        // DATA load stalls until a byte arrives
        @(negedge clk);
        uart = 1'b1; read = 1'b1; address = 32'h0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("stall_get", {31'b0, get}, 32'd0);
        end
        frame = {1'b1, 8'h5A, 1'b0};
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            chk("rx_load_get", {31'b0, get}, (k == 42) ? 32'd1 : 32'd0);
            if (k == 42) chk("rx_load_data", rdata, 32'h0000_005A);
            rx = (k < 40) ? frame[k/4] : 1'b1;
        end
        read = 1'b0; uart = 1'b0;
        do_load("stat_after_rx", 32'h4, 32'h0);

        // Overrun: 0x11 kept, 0x22 dropped
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        do_load("ovr_data", 32'h0, 32'h0000_0011);
        do_load("ovr_stat", 32'h4, 32'h04);
        do_load("ovr_clear", 32'h4, 32'h0);

        // Framing error
        send_frame(8'h33, 1'b0);
        repeat (4) @(negedge clk);
        do_load("ferr_stat", 32'h4, 32'h08);
        do_load("ferr_clear", 32'h4, 32'h0);

        // One-cycle low glitch is rejected
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (50) @(negedge clk);
        do_load("glitch_stat", 32'h4, 32'h0);

        // Reset mid-frame, then a clean frame
        @(negedge clk);
        uart = 1'b1; write = 1'b1; address = 32'h0; wdata = 32'h0000_0096;
        @(negedge clk);
        write = 1'b0; uart = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst_busy", {31'b0, tx_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", {31'b0, tx}, 32'd1);
        chk("mid_rst_busy", {31'b0, tx_busy}, 32'd0);
        rst = 1'b0;
        uart = 1'b1; write = 1'b1; address = 32'h0; wdata = 32'h0000_00C3;
        frame = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("tx2_bit", {31'b0, tx}, {31'b0, frame[k/4]});
            chk("tx2_busy", {31'b0, tx_busy}, 32'd1);
            if (k == 0) begin write = 1'b0; uart = 1'b0; end
        end
        @(negedge clk);
        chk("tx2_done_busy", {31'b0, tx_busy}, 32'd0);
        chk("tx2_done_line", {31'b0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_mmio_unit.md
Name: uart_mmio_unit

Overview:
- Memory-mapped UART peripheral directly downstream of the LSU controller.
- Consumes the LSU's uart-select, read and write strobes, plus the store data.
- Serialises TX bytes, deserialises RX bytes and returns load data.
- Asserts `get` to release the load stall the LSU raises on UART loads.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
- SYNC_STAGES, 2, flops in the rx input synchroniser.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- uart  in  1  LSU select: the current access targets the UART window
- write  in  1  store strobe from the LSU
- read  in  1  load strobe from the LSU
- address  in  32  access address; only [3:2] is decoded inside the window
- wdata  in  32  store data; only [7:0] is used
- rx  in  1  serial input, idle high, asynchronous
- tx  out  1  serial output, idle high
- rdata  out  32  load data, zero-extended; valid only while get=1
- get  out  1  load-complete pulse to the LSU controller
- tx_busy  out  1  high while a frame is being transmitted

Behaviour:
- Reset values: tx=1, get=0, rdata=0, tx_busy=0; both FSMs IDLE; rx_valid, rx_buf and all sticky flags cleared.
- Reset asserted mid-frame aborts the frame; tx=1 on the next edge.
- Register map (address[3:2]):
  - 0 = DATA. Write: TX byte. Read: RX byte.
  - 1 = STATUS, read-only: bit0 rx_valid, bit1 tx_busy, bit2 rx_overrun, bit3 rx_frame_err, bit4 tx_drop.
  - 2 and 3: reads return 0, writes are ignored.
- Access qualifiers: an access is act = uart & (read | write). Write has priority if both are set; this is treated as a write only.
- TX store, DATA while tx_busy=0:
  - wdata[7:0] is latched at the edge.
  - tx_busy=1 from the next cycle.
  - The FSM goes IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state bit lasts exactly CLKS_PER_BIT cycles; the start bit begins the cycle after the store.
  - tx_busy falls the cycle after the stop bit completes, so the frame is 10*CLKS_PER_BIT cycles.
- TX store while tx_busy=1: the byte is dropped and tx_drop is set (sticky).
- A store is accepted in the cycle it is presented. get is never asserted for stores.
- Load of STATUS:
  - get=1 and rdata=status exactly one cycle after the first cycle read&uart is seen.
  - The reported status is the value captured at that first cycle.
  - bits 2..4 clear on the get cycle unless re-set in that same cycle; a set in the same cycle wins.
- Load of DATA:
  - If rx_valid=1: get=1 one cycle later with rdata={24'b0, rx_buf}, and rx_valid clears on the get cycle.
  - If rx_valid=0: get stays 0 while read&uart is held (the LSU stalls). get=1 the cycle after rx_valid rises.
- get handshake:
  - get is a registered single-cycle pulse.
  - After a pulse, get stays 0 for at least one cycle even if read&uart remains high, so a back-to-back load is a new access.
  - If read drops before get fires, the pending load is abandoned and no buffer is consumed.
- RX path:
  - rx passes through SYNC_STAGES flops.
  - A falling edge in IDLE enters START. The line is re-sampled at CLKS_PER_BIT/2; if it is high, this was a glitch and the FSM returns to IDLE.
  - Otherwise 8 data bits are sampled at each mid-bit, then the stop bit is sampled.
  - Stop bit = 1: the byte is written to rx_buf and rx_valid=1.
  - Stop bit = 0: the byte is discarded and rx_frame_err is set.
  - The FSM returns to IDLE right after the stop sample.
- RX overrun: if a byte completes while rx_valid=1, the old byte is kept, the new byte is dropped and rx_overrun is set.
- Simultaneous events:
  - If a byte completes in the same cycle a DATA-load get consumes the buffer, the new byte is stored and rx_valid stays 1 with no overrun.
  - TX and RX are fully independent.

Test Plan:
1. CLKS_PER_BIT=4; store wdata=0x000000A5 to DATA -> tx sequence is 0 then 1,0,1,0,0,1,0,1 then 1, each bit held 4 cycles; tx_busy=1 for 40 cycles.
2. A second store of 0x3C during scenario 1's frame -> tx unaffected; a later STATUS load returns 0x12 with get one cycle after read; a further STATUS load returns bit4=0.
3. DATA load with rx idle, held 30 cycles, then drive the frame for 0x5A on rx -> get=0 throughout until the cycle after rx_valid; get=1 with rdata=0x0000005A for exactly one cycle; rx_valid=0 afterwards.
4. Receive 0x11 then 0x22 without any load -> DATA load returns 0x11; STATUS shows bit2=1.
5. Receive a frame with stop bit 0 -> rx_valid stays 0; STATUS bit3=1 and is cleared on the next STATUS read.
6. Assert rst midway through a TX frame -> tx=1, tx_busy=0 on the next edge; a new store afterwards transmits correctly.
